// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module  : cpu_ctrl_pkg
// Brief   : Opcodes, control-word bit map, T-state encoding and fetch words
//           shared by the 8-bit CPU control sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam int         CTRL_W   = 16;
    localparam int         STEP_W   = 3;
    localparam logic [4:0] MAX_STEP = 5'd4;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        HALT     = 4'd0,
        MAR_IN   = 4'd1,
        RAM_IN   = 4'd2,
        RAM_OUT  = 4'd3,
        IR_IN    = 4'd4,
        IR_OUT   = 4'd5,
        A_IN     = 4'd6,
        A_OUT    = 4'd7,
        SUM_OUT  = 4'd8,
        SUBTRACT = 4'd9,
        B_IN     = 4'd10,
        OUT_IN   = 4'd11,
        PC_EN    = 4'd12,
        PC_OUT   = 4'd13,
        JUMP     = 4'd14,
        FLAGS_IN = 4'd15
    } ctrl_e;

    typedef enum logic [STEP_W-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_e;

    function automatic logic [CTRL_W-1:0] cbit(input ctrl_e b);
        logic [CTRL_W-1:0] w;
        w    = '0;
        w[b] = 1'b1;
        return w;
    endfunction

    localparam logic [CTRL_W-1:0] FETCH_T0 = (16'h0001 << PC_OUT) | (16'h0001 << MAR_IN);
    localparam logic [CTRL_W-1:0] FETCH_T1 = (16'h0001 << RAM_OUT) | (16'h0001 << IR_IN)
                                           | (16'h0001 << PC_EN);

endpackage

`default_nettype wire

// File: rtl/control_sequencer_if.sv
// ============================================================================
// Module  : control_sequencer_if
// Brief   : Opcode/flag inputs and control-word/status outputs of the
//           control sequencer, with master (IR/ALU side) and slave modports.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic [3:0]        opcode;
    logic              carry_flag;
    logic              zero_flag;
    logic [CTRL_W-1:0] ctrl;
    logic [STEP_W-1:0] step;
    logic              halted;

    modport master (
        output opcode, carry_flag, zero_flag,
        input  ctrl, step, halted
    );

    modport slave (
        input  opcode, carry_flag, zero_flag,
        output ctrl, step, halted
    );
endinterface

`default_nettype wire

// File: rtl/control_sequencer_microcode_rom.sv
// ============================================================================
// Module  : microcode_rom
// Brief   : Combinational microcode: {opcode, step, carry, zero} -> {ctrl, last}.
//           Macro CTRL_COND_JUMP_EN enables JC/JZ; otherwise they act as NOP.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module microcode_rom
    import cpu_ctrl_pkg::*;
(
    input  wire logic [3:0]        i_opcode,
    input  wire logic [STEP_W-1:0] i_step,
    input  wire logic              i_carry,
    input  wire logic              i_zero,
    output logic      [CTRL_W-1:0] o_ctrl,
    output logic                   o_last
);

    logic [CTRL_W-1:0] w_ctrl;
    logic              w_last;
    logic              w_long;

`ifndef CTRL_COND_JUMP_EN
    logic w_unused_flags;
    assign w_unused_flags = i_carry ^ i_zero;
`endif

    // w_long: instruction has an execute phase beyond the fetch cycles
    always_comb begin
        w_long = 1'b0;
        case (i_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA,
            OP_LDI, OP_JMP, OP_OUT, OP_HLT: w_long = 1'b1;
`ifdef CTRL_COND_JUMP_EN
            OP_JC:                          w_long = i_carry;
            OP_JZ:                          w_long = i_zero;
`endif
            default:                        w_long = 1'b0;
        endcase
    end

    always_comb begin
        w_ctrl = '0;
        w_last = 1'b1;
        case (i_step)
            T0: begin
                w_ctrl = FETCH_T0;
                w_last = 1'b0;
            end
            T1: begin
                w_ctrl = FETCH_T1;
                w_last = !w_long;
            end
            T2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        w_ctrl = cbit(IR_OUT) | cbit(MAR_IN);
                        w_last = 1'b0;
                    end
                    OP_LDI:  w_ctrl = cbit(IR_OUT) | cbit(A_IN);
                    OP_JMP:  w_ctrl = cbit(IR_OUT) | cbit(JUMP);
                    OP_OUT:  w_ctrl = cbit(A_OUT) | cbit(OUT_IN);
                    OP_HLT:  w_ctrl = cbit(HALT);
`ifdef CTRL_COND_JUMP_EN
                    OP_JC:   w_ctrl = i_carry ? (cbit(IR_OUT) | cbit(JUMP)) : '0;
                    OP_JZ:   w_ctrl = i_zero  ? (cbit(IR_OUT) | cbit(JUMP)) : '0;
`endif
                    default: w_ctrl = '0;
                endcase
            end
            T3: begin
                case (i_opcode)
                    OP_LDA:  w_ctrl = cbit(RAM_OUT) | cbit(A_IN);
                    OP_ADD, OP_SUB: begin
                        w_ctrl = cbit(RAM_OUT) | cbit(B_IN);
                        w_last = 1'b0;
                    end
                    OP_STA:  w_ctrl = cbit(A_OUT) | cbit(RAM_IN);
                    default: w_ctrl = '0;
                endcase
            end
            T4: begin
                case (i_opcode)
                    OP_ADD:  w_ctrl = cbit(SUM_OUT) | cbit(A_IN) | cbit(FLAGS_IN);
                    OP_SUB:  w_ctrl = cbit(SUM_OUT) | cbit(A_IN) | cbit(FLAGS_IN)
                                    | cbit(SUBTRACT);
                    default: w_ctrl = '0;
                endcase
            end
            default: begin
                w_ctrl = '0;
                w_last = 1'b1;
            end
        endcase
    end

    assign o_ctrl = w_ctrl;
    assign o_last = w_last;

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module  : control_sequencer
// Brief   : T-state step counter, halt register and control-word forcing for
//           the 8-bit CPU. Conditional jumps follow macro CTRL_COND_JUMP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    control_sequencer_if.slave bus
);

    localparam step_e STEP_LAST = step_e'(MAX_STEP[STEP_W-1:0]);

    step_e             r_step;
    logic              r_halted;
    logic [CTRL_W-1:0] w_rom_ctrl;
    logic              w_rom_last;

    microcode_rom u_rom (
        .i_opcode (bus.opcode),
        .i_step   (r_step),
        .i_carry  (bus.carry_flag),
        .i_zero   (bus.zero_flag),
        .o_ctrl   (w_rom_ctrl),
        .o_last   (w_rom_last)
    );

    // HLT freezes the counter at T2; only reset leaves the halted state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step   <= T0;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (w_rom_ctrl[HALT]) begin
                r_halted <= 1'b1;
            end else if (w_rom_last || (r_step >= STEP_LAST)) begin
                r_step <= T0;
            end else begin
                r_step <= step_e'(r_step + 3'd1);
            end
        end
    end

    assign bus.ctrl   = !rst     ? '0
                      : r_halted ? cbit(HALT)
                      :            w_rom_ctrl;
    assign bus.step   = r_step;
    assign bus.halted = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module  : tb_control_sequencer
// Brief   : Scoreboard bench: stimulus pushes expected per-cycle outputs from
//           an instruction-level model; a negedge monitor pops and compares.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef CTRL_COND_JUMP_EN
    localparam bit COND_EN = 1'b1;
`else
    localparam bit COND_EN = 1'b0;
`endif

    localparam logic [15:0] B_HALT     = 16'h0001;
    localparam logic [15:0] B_MAR_IN   = 16'h0002;
    localparam logic [15:0] B_RAM_IN   = 16'h0004;
    localparam logic [15:0] B_RAM_OUT  = 16'h0008;
    localparam logic [15:0] B_IR_IN    = 16'h0010;
    localparam logic [15:0] B_IR_OUT   = 16'h0020;
    localparam logic [15:0] B_A_IN     = 16'h0040;
    localparam logic [15:0] B_A_OUT    = 16'h0080;
    localparam logic [15:0] B_SUM_OUT  = 16'h0100;
    localparam logic [15:0] B_SUBTRACT = 16'h0200;
    localparam logic [15:0] B_B_IN     = 16'h0400;
    localparam logic [15:0] B_OUT_IN   = 16'h0800;
    localparam logic [15:0] B_PC_EN    = 16'h1000;
    localparam logic [15:0] B_PC_OUT   = 16'h2000;
    localparam logic [15:0] B_JUMP     = 16'h4000;
    localparam logic [15:0] B_FLAGS_IN = 16'h8000;

    typedef struct packed {
        logic [2:0]  step;
        logic [15:0] ctrl;
        logic        halted;
        logic [3:0]  op;
    } exp_t;

    exp_t        q[$];
    logic [15:0] seq[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Instruction-level model: list of control words, one per cycle
    function automatic void build_seq(input logic [3:0] op, input logic c, input logic z);
        seq.delete();
        seq.push_back(B_PC_OUT | B_MAR_IN);
        seq.push_back(B_RAM_OUT | B_IR_IN | B_PC_EN);
        case (op)
            4'h1: begin seq.push_back(B_IR_OUT | B_MAR_IN); seq.push_back(B_RAM_OUT | B_A_IN); end
            4'h2: begin
                seq.push_back(B_IR_OUT | B_MAR_IN);
                seq.push_back(B_RAM_OUT | B_B_IN);
                seq.push_back(B_SUM_OUT | B_A_IN | B_FLAGS_IN);
            end
            4'h3: begin
                seq.push_back(B_IR_OUT | B_MAR_IN);
                seq.push_back(B_RAM_OUT | B_B_IN);
                seq.push_back(B_SUM_OUT | B_A_IN | B_FLAGS_IN | B_SUBTRACT);
            end
            4'h4: begin seq.push_back(B_IR_OUT | B_MAR_IN); seq.push_back(B_A_OUT | B_RAM_IN); end
            4'h5: seq.push_back(B_IR_OUT | B_A_IN);
            4'h6: seq.push_back(B_IR_OUT | B_JUMP);
            4'h7: if (COND_EN && c) seq.push_back(B_IR_OUT | B_JUMP);
            4'h8: if (COND_EN && z) seq.push_back(B_IR_OUT | B_JUMP);
            4'hE: seq.push_back(B_A_OUT | B_OUT_IN);
            4'hF: seq.push_back(B_HALT);
            default: ;
        endcase
    endfunction

    task automatic push_exp(input int st, input logic [15:0] cw, input logic h, input logic [3:0] op);
        exp_t e;
        e.step   = 3'(st);
        e.ctrl   = cw;
        e.halted = h;
        e.op     = op;
        q.push_back(e);
    endtask

    // Called at posedge+1 of the T0 cycle; returns at posedge+1 after the last cycle
    task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
        bus.opcode     = op;
        bus.carry_flag = c;
        bus.zero_flag  = z;
        build_seq(op, c, z);
        for (int i = 0; i < seq.size(); i++) begin
            push_exp(i, seq[i], 1'b0, op);
            @(posedge clk); #1;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("op%h step", e.op), 32'(bus.step), 32'(e.step));
            check($sformatf("op%h T%0d ctrl", e.op, e.step), 32'(bus.ctrl), 32'(e.ctrl));
            check($sformatf("op%h T%0d halted", e.op, e.step), 32'(bus.halted), 32'(e.halted));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.opcode     = 4'h1;
        bus.carry_flag = 1'b0;
        bus.zero_flag  = 1'b0;
        rst            = 1'b0;

        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            push_exp(0, 16'h0000, 1'b0, 4'h1);
            @(posedge clk); #1;
        end
        rst = 1'b1;

        run_instr(4'h1, 1'b0, 1'b0);
        run_instr(4'h1, 1'b1, 1'b1);
        run_instr(4'h2, 1'b0, 1'b0);
        run_instr(4'h3, 1'b1, 1'b0);
        run_instr(4'h7, 1'b1, 1'b0);
        run_instr(4'h7, 1'b0, 1'b1);
        run_instr(4'h8, 1'b0, 1'b1);
        run_instr(4'h8, 1'b1, 1'b0);
        run_instr(4'h4, 1'b0, 1'b0);
        run_instr(4'h5, 1'b0, 1'b0);
        run_instr(4'h6, 1'b0, 1'b0);
        run_instr(4'hE, 1'b0, 1'b0);
        run_instr(4'hA, 1'b0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            run_instr(4'($urandom_range(0, 14)), 1'($urandom), 1'($urandom));
        end

        // Halt, stay frozen, then pulse reset
        run_instr(4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            push_exp(2, B_HALT, 1'b1, 4'hF);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        check("hlt reset step", 32'(bus.step), 32'd0);
        check("hlt reset halted", 32'(bus.halted), 32'd0);
        check("hlt reset ctrl", 32'(bus.ctrl), 32'd0);
        push_exp(0, 16'h0000, 1'b0, 4'hF);
        @(posedge clk); #1;
        rst = 1'b1;
        run_instr(4'h5, 1'b0, 1'b0);

        // Asynchronous reset in the middle of ADD at T3
        bus.opcode = 4'h2;
        build_seq(4'h2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push_exp(i, seq[i], 1'b0, 4'h2);
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("midadd reset step", 32'(bus.step), 32'd0);
        check("midadd reset ctrl", 32'(bus.ctrl), 32'd0);
        @(posedge clk); #1;
        push_exp(0, 16'h0000, 1'b0, 4'h2);
        @(posedge clk); #1;
        rst = 1'b1;
        run_instr(4'hA, 1'b0, 1'b0);
        run_instr(4'h2, 1'b0, 1'b0);

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("queue drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
